// File: rtl/bcd_updown_cnt_if.sv
// Control and status bundle for the BCD up/down counter.
// The master drives load/step requests; the counter (slave) returns count and event flags.
interface bcd_updown_cnt_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   data;
    logic                  inc;
    logic                  down;
    logic [4*DIGITS-1:0]   count;
    logic                  carry;
    logic                  err;

    modport master (
        output load,
        output data,
        output inc,
        output down,
        input  count,
        input  carry,
        input  err
    );

    modport slave (
        input  load,
        input  data,
        input  inc,
        input  down,
        output count,
        output carry,
        output err
    );
endinterface

// File: rtl/bcd_updown_cnt.sv
// Multi-digit BCD up/down counter with validated parallel load, wrap or saturate at the
// limits, and registered one-cycle limit (carry) and rejected-load (err) flags.
module bcd_updown_cnt #(
    parameter int DIGITS = 4,
    parameter int WRAP   = 1
) (
    input  logic            clk,
    input  logic            reset,
    bcd_updown_cnt_if.slave bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] count_r;
    logic         carry_r;
    logic         err_r;

    logic [W-1:0] inc_val_s;
    logic [W-1:0] dec_val_s;
    logic         all9_s;
    logic         all0_s;
    logic         load_ok_s;
    logic [W-1:0] count_nxt_s;
    logic         carry_nxt_s;
    logic         err_nxt_s;

    // True only when every nibble is a legal decimal digit.
    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // Decimal +1 with ripple: a 9 rolls to 0 only while every lower digit also rolled.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (c) begin
                if (v[4*k +: 4] == 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                    c           = 1'b1;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    // Decimal -1 with ripple: a 0 rolls to 9 only while every lower digit also rolled.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (b) begin
                if (v[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                    b           = 1'b1;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                    b           = 1'b0;
                end
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    // Every digit equal to the given value (used for the all-9s / all-0s limits).
    function automatic logic bcd_all(input logic [W-1:0] v, input logic [3:0] d);
        logic eq;
        eq = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] != d) begin
                eq = 1'b0;
            end else begin
                eq = eq;
            end
        end
        return eq;
    endfunction

    // Precompute both step results and the limit conditions from the current count.
    always_comb begin
        inc_val_s = bcd_inc(count_r);
        dec_val_s = bcd_dec(count_r);
        all9_s    = bcd_all(count_r, 4'd9);
        all0_s    = bcd_all(count_r, 4'd0);
        load_ok_s = bcd_valid(bus.data);
    end

    // Next-state selection with priority load over step; reset is applied in the register.
    always_comb begin
        count_nxt_s = count_r;
        carry_nxt_s = 1'b0;
        err_nxt_s   = 1'b0;
        case ({bus.load, bus.inc})
            2'b10, 2'b11: begin
                if (load_ok_s) begin
                    count_nxt_s = bus.data;
                end else begin
                    err_nxt_s = 1'b1;
                end
            end
            2'b01: begin
                if (bus.down) begin
                    if (all0_s) begin
                        // At the bottom limit: wrap to all-9s or hold, flagging either way.
                        count_nxt_s = (WRAP != 0) ? dec_val_s : count_r;
                        carry_nxt_s = 1'b1;
                    end else begin
                        count_nxt_s = dec_val_s;
                    end
                end else begin
                    if (all9_s) begin
                        count_nxt_s = (WRAP != 0) ? inc_val_s : count_r;
                        carry_nxt_s = 1'b1;
                    end else begin
                        count_nxt_s = inc_val_s;
                    end
                end
            end
            default: begin
                count_nxt_s = count_r;
                carry_nxt_s = 1'b0;
                err_nxt_s   = 1'b0;
            end
        endcase
    end

    // State and flag registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
            carry_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            carry_r <= carry_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    assign bus.count = count_r;
    assign bus.carry = carry_r;
    assign bus.err   = err_r;

endmodule

// File: tb/tb_bcd_updown_cnt.sv
// Directed bench for bcd_updown_cnt: three instances (2-digit wrap, 2-digit saturate,
// 4-digit wrap) driven one at a time with hand-computed expected values.
module tb_bcd_updown_cnt;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    bcd_updown_cnt_if #(.DIGITS(2)) bus_a ();
    bcd_updown_cnt_if #(.DIGITS(2)) bus_b ();
    bcd_updown_cnt_if #(.DIGITS(4)) bus_c ();

    bcd_updown_cnt #(.DIGITS(2), .WRAP(1)) u_a (.clk(clk), .reset(reset), .bus(bus_a));
    bcd_updown_cnt #(.DIGITS(2), .WRAP(0)) u_b (.clk(clk), .reset(reset), .bus(bus_b));
    bcd_updown_cnt #(.DIGITS(4), .WRAP(1)) u_c (.clk(clk), .reset(reset), .bus(bus_c));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one cycle on the selected instance (0=a,1=b,2=c); the others idle.
    task automatic drive(input int sel, input logic rst, input logic ld,
                         input logic [15:0] dat, input logic in, input logic dn);
        reset      = rst;
        bus_a.load = 1'b0; bus_a.data = 8'h00;  bus_a.inc = 1'b0; bus_a.down = 1'b0;
        bus_b.load = 1'b0; bus_b.data = 8'h00;  bus_b.inc = 1'b0; bus_b.down = 1'b0;
        bus_c.load = 1'b0; bus_c.data = 16'h0000; bus_c.inc = 1'b0; bus_c.down = 1'b0;
        case (sel)
            0: begin bus_a.load = ld; bus_a.data = dat[7:0]; bus_a.inc = in; bus_a.down = dn; end
            1: begin bus_b.load = ld; bus_b.data = dat[7:0]; bus_b.inc = in; bus_b.down = dn; end
            default: begin bus_c.load = ld; bus_c.data = dat; bus_c.inc = in; bus_c.down = dn; end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [7:0] cnt, input logic cy, input logic er);
        check({tag, "_cnt"}, {24'd0, bus_a.count}, {24'd0, cnt});
        check({tag, "_carry"}, {31'd0, bus_a.carry}, {31'd0, cy});
        check({tag, "_err"}, {31'd0, bus_a.err}, {31'd0, er});
    endtask

    task automatic chk_b(input string tag, input logic [7:0] cnt, input logic cy, input logic er);
        check({tag, "_cnt"}, {24'd0, bus_b.count}, {24'd0, cnt});
        check({tag, "_carry"}, {31'd0, bus_b.carry}, {31'd0, cy});
        check({tag, "_err"}, {31'd0, bus_b.err}, {31'd0, er});
    endtask

    task automatic chk_c(input string tag, input logic [15:0] cnt, input logic cy, input logic er);
        check({tag, "_cnt"}, {16'd0, bus_c.count}, {16'd0, cnt});
        check({tag, "_carry"}, {31'd0, bus_c.carry}, {31'd0, cy});
        check({tag, "_err"}, {31'd0, bus_c.err}, {31'd0, er});
    endtask

    initial begin
        clk          = 1'b0;
        tests_run    = 0;
        tests_failed = 0;

        // Reset with garbage on the inputs must still clear everything.
        drive(0, 1'b1, 1'b1, 16'h0055, 1'b1, 1'b0);
        drive(0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        chk_a("rst_a", 8'h00, 1'b0, 1'b0);
        chk_b("rst_b", 8'h00, 1'b0, 1'b0);
        chk_c("rst_c", 16'h0000, 1'b0, 1'b0);

        // Twelve up steps from zero: 01..09,10,11,12 with no carry.
        for (int i = 1; i <= 12; i++) begin
            drive(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
            check("up_seq_cnt", {24'd0, bus_a.count}, 32'((i / 10) * 16 + (i % 10)));
            check("up_seq_carry", {31'd0, bus_a.carry}, 32'd0);
        end

        // Wrap at the top.
        drive(0, 1'b0, 1'b1, 16'h0098, 1'b0, 1'b0); chk_a("ld98", 8'h98, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); chk_a("up99", 8'h99, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); chk_a("wrap00", 8'h00, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); chk_a("up01", 8'h01, 1'b0, 1'b0);

        // Direction flips take effect on the very next step; wrap at the bottom.
        drive(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); chk_a("dn00", 8'h00, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); chk_a("flip01", 8'h01, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); chk_a("flip00", 8'h00, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); chk_a("wrap99", 8'h99, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1); chk_a("hold99", 8'h99, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); chk_a("dn98", 8'h98, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); chk_a("dn97", 8'h97, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); chk_a("dn96", 8'h96, 1'b0, 1'b0);

        // Rejected loads keep the count and pulse err; a good load beats inc.
        drive(0, 1'b0, 1'b1, 16'h0045, 1'b0, 1'b0); chk_a("ld45", 8'h45, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b1, 16'h004A, 1'b1, 1'b0); chk_a("bad4A", 8'h45, 1'b0, 1'b1);
        drive(0, 1'b0, 1'b1, 16'h00F0, 1'b0, 1'b0); chk_a("badF0", 8'h45, 1'b0, 1'b1);
        drive(0, 1'b0, 1'b1, 16'h0037, 1'b1, 1'b0); chk_a("ld37", 8'h37, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0); chk_a("hold37", 8'h37, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); chk_a("up38", 8'h38, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); chk_a("dn37", 8'h37, 1'b0, 1'b0);

        // Reset beats a concurrent load and step; next step starts from zero.
        drive(0, 1'b1, 1'b1, 16'h0066, 1'b1, 1'b0); chk_a("rst_ld", 8'h00, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); chk_a("rst_up01", 8'h01, 1'b0, 1'b0);

        // Saturating instance at the bottom.
        drive(1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0); chk_b("s_ld01", 8'h01, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); chk_b("s_dn00", 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); chk_b("s_sat0a", 8'h00, 1'b1, 1'b0);
        drive(1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); chk_b("s_sat0b", 8'h00, 1'b1, 1'b0);
        drive(1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); chk_b("s_up01", 8'h01, 1'b0, 1'b0);

        // Saturating instance at the top.
        drive(1, 1'b0, 1'b1, 16'h0098, 1'b0, 1'b0); chk_b("s_ld98", 8'h98, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); chk_b("s_up99", 8'h99, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); chk_b("s_sat9a", 8'h99, 1'b1, 1'b0);
        drive(1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); chk_b("s_sat9b", 8'h99, 1'b1, 1'b0);
        drive(1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); chk_b("s_dn98", 8'h98, 1'b0, 1'b0);

        // Four-digit ripple through several digits, both directions.
        drive(2, 1'b0, 1'b1, 16'h0999, 1'b0, 1'b0); chk_c("w_ld0999", 16'h0999, 1'b0, 1'b0);
        drive(2, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); chk_c("w_up1000", 16'h1000, 1'b0, 1'b0);
        drive(2, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); chk_c("w_dn0999", 16'h0999, 1'b0, 1'b0);
        drive(2, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0); chk_c("w_ld0000", 16'h0000, 1'b0, 1'b0);
        drive(2, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); chk_c("w_wrap9999", 16'h9999, 1'b1, 1'b0);
        drive(2, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); chk_c("w_wrap0000", 16'h0000, 1'b1, 1'b0);
        drive(2, 1'b0, 1'b1, 16'h1A00, 1'b0, 1'b0); chk_c("w_bad1A00", 16'h0000, 1'b0, 1'b1);
        drive(2, 1'b0, 1'b1, 16'h4090, 1'b0, 1'b0); chk_c("w_ld4090", 16'h4090, 1'b0, 1'b0);
        drive(2, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); chk_c("w_dn4089", 16'h4089, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
